uart_rx_fifo_receiver: RTL and testbench

UART receiver for the SOC's `ftdi_rxd` line.
- Synchronises the serial input and recovers 8N1 frames at a fixed baud rate.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Presents buffered bytes on a valid/ready port that the IO page reads as the RX data and status words.
- This is the receive counterpart of the UART transmitter that already hangs off the IO page.

---
 rtl/uart_rx_fifo_receiver_pkg.sv | 28 ++
 rtl/uart_rx_fifo_receiver_if.sv | 26 ++
 rtl/uart_rx_fifo_receiver_byte_fifo.sv | 63 ++++++
 rtl/uart_rx_fifo_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_rx_fifo_receiver.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_receiver_pkg.sv
// Shared definitions for the UART receive path.
// - Receiver state encodings (3-bit).
// - IO page bit positions for the RX data and status words.
// - A helper that packs the status word the IO page returns.
package uart_rx_fifo_receiver_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // IO page select bits. A read of the data word returns {24'b0, o_data} and
  // pulses i_ready for one cycle; a write to the status word pulses i_clr_err.
  localparam int IO_UART_RX_DAT_bit  = 3;
  localparam int IO_UART_RX_STAT_bit = 4;

  function automatic logic [31:0] rx_stat_word(input logic frame_err,
                                               input logic overrun,
                                               input logic valid);
    return {29'b0, frame_err, overrun, valid};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_receiver_if.sv
// Consumer-side bus of the UART receiver.
// - o_data/o_valid/i_ready : FIFO head byte with valid/ready pop handshake.
// - o_overrun/o_frame_err  : sticky error flags.
// - i_clr_err              : one-cycle pulse clearing both sticky flags.
// master = receiver, slave = consumer (IO page).
interface uart_rx_fifo_receiver_if;
  import uart_rx_fifo_receiver_pkg::*;

  logic [BYTE_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_overrun;
  logic              o_frame_err;
  logic              i_clr_err;

  modport master (
    output o_data, o_valid, o_overrun, o_frame_err,
    input  i_ready, i_clr_err
  );

  modport slave (
    input  o_data, o_valid, o_overrun, o_frame_err,
    output i_ready, i_clr_err
  );

endinterface

// File: rtl/uart_rx_fifo_receiver_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO.
// Ports:
//   clk, resetn         : clock, asynchronous active-low reset (pointers only)
//   push, push_data     : write request and byte
//   pop                 : read request; ignored when empty
//   head_data           : current head byte (0 while empty)
//   not_empty           : FIFO holds at least one byte
//   drop                : pulse, a push was refused because the FIFO was full
module uart_byte_fifo
  import uart_rx_fifo_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head_data,
  output logic              not_empty,
  output logic              drop
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // accepted in that case and occupancy stays the same.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Storage is not reset, so the head is forced to 0 while empty.
  assign not_empty = ~empty;
  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// uart_rx_fifo_receiver: 8N1 UART receiver with a FWFT byte FIFO.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   i_rx   : raw serial line (asynchronous, idles high)
//   rx_if  : master side of uart_rx_fifo_receiver_if (head byte, valid/ready
//            pop, sticky overrun/frame-error flags and their clear pulse)
module uart_rx_fifo_receiver
  import uart_rx_fifo_receiver_pkg::*;
#(
  parameter int clk_freq_hz = 25000000,
  parameter int baud_rate   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_rx,
  uart_rx_fifo_receiver_if.master rx_if
);

  localparam int DIV   = clk_freq_hz / baud_rate;
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  logic              rx_sync_p0;
  logic              rx_s;

  rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        bitidx, bitidx_nxt;
  logic [BYTE_W-1:0] sh, sh_nxt;
  logic              expired;
  logic              push;
  logic              frame_err_evt;

  logic              fifo_drop;
  logic              fifo_not_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic              overrun_q;
  logic              frame_err_q;

  // ---- synchroniser: i_rx -> rx_sync_p0 -> rx_s (idle-high reset) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= i_rx;
      rx_s       <= rx_sync_p0;
    end
  end

  // ---- frame recovery FSM ----
  assign expired = (cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bitidx <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bitidx <= bitidx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    sh <= sh_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = expired ? cnt : cnt - CNT_W'(1);
    bitidx_nxt    = bitidx;
    sh_nxt        = sh;
    push          = 1'b0;
    frame_err_evt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          // Half a bit to land the start sample mid-bit.
          cnt_nxt   = CNT_HALF;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (expired) begin
          if (!rx_s) begin
            cnt_nxt    = CNT_FULL;
            bitidx_nxt = '0;
            state_nxt  = ST_DATA;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expired) begin
          sh_nxt     = {rx_s, sh[BYTE_W-1:1]};
          bitidx_nxt = bitidx + 3'd1;
          cnt_nxt    = CNT_FULL;
          if (bitidx == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (expired) begin
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err_evt = 1'b1;
            state_nxt     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must not be taken as a new start bit.
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- byte buffer ----
  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (sh),
    .pop       (rx_if.i_ready),
    .head_data (fifo_head),
    .not_empty (fifo_not_empty),
    .drop      (fifo_drop)
  );

  // ---- sticky flags: a new event wins over a coincident clear ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= (overrun_q   & ~rx_if.i_clr_err) | fifo_drop;
      frame_err_q <= (frame_err_q & ~rx_if.i_clr_err) | frame_err_evt;
    end
  end

  assign rx_if.o_data      = fifo_head;
  assign rx_if.o_valid     = fifo_not_empty;
  assign rx_if.o_overrun   = overrun_q;
  assign rx_if.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// Testbench for uart_rx_fifo_receiver: serial frames are driven on i_rx,
// expected bytes and flags come from a queue-based model of the receive
// buffer, and a monitor checks every pop against the expected queue.
module tb_uart_rx_fifo_receiver;
  import uart_rx_fifo_receiver_pkg::*;

  localparam int CLK_HZ = 25000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
  localparam int DIV    = CLK_HZ / BAUD;
  // Edges from driving the start bit to the stop sample: 2 synchroniser
  // edges + 1 edge for IDLE to see it, then DIV/2 + 9*DIV.
  localparam int STOP_OFS = 3 + DIV / 2 + 9 * DIV;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic i_rx   = 1'b1;

  uart_rx_fifo_receiver_if rx_if();

  uart_rx_fifo_receiver #(
    .clk_freq_hz (CLK_HZ),
    .baud_rate   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .i_rx   (i_rx),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovr  = 1'b0;
  bit         exp_fe   = 1'b0;
  logic [7:0] fill_b;
  logic [7:0] rnd_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the consumer asserts ready, the DUT must agree with
  // the model about having data, and the head must match the model's head.
  always @(negedge clk) begin
    logic [7:0] head;
    if (resetn === 1'b1 && rx_if.i_ready === 1'b1) begin
      chk("pop_valid", {31'b0, rx_if.o_valid}, {31'b0, exp_q.size() != 0});
      if (rx_if.o_valid === 1'b1 && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        chk("pop_data", {24'b0, rx_if.o_data}, {24'b0, head});
      end
    end
  end

  // Behavioural buffer model: a completed frame is kept if there is room,
  // otherwise it is lost and the overrun flag is raised.
  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ovr = 1'b1;
  endtask

  task automatic check_status(input string name);
    chk({name, "_valid"}, {31'b0, rx_if.o_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0)
      chk({name, "_data"}, {24'b0, rx_if.o_data}, {24'b0, exp_q[0]});
    chk({name, "_ovr"}, {31'b0, rx_if.o_overrun}, {31'b0, exp_ovr});
    chk({name, "_fe"}, {31'b0, rx_if.o_frame_err}, {31'b0, exp_fe});
  endtask

  // All drivers assume they are entered just after a rising edge.
  task automatic hold(input logic v, input int n);
    i_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    hold(1'b0, DIV);
    for (int k = 0; k < 8; k++) hold(b[k], DIV);
    if (stop_low > 0) hold(1'b0, stop_low);
    hold(1'b1, DIV);
  endtask

  task automatic drain(input int n);
    rx_if.i_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rx_if.i_ready = 1'b0;
  endtask

  task automatic clr_flags();
    rx_if.i_clr_err = 1'b1;
    @(posedge clk);
    #1;
    rx_if.i_clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.i_ready   = 1'b0;
    rx_if.i_clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, rx_if.o_valid}, 32'd0);
    chk("rst_data", {24'b0, rx_if.o_data}, 32'd0);
    chk("rst_ovr", {31'b0, rx_if.o_overrun}, 32'd0);
    chk("rst_fe", {31'b0, rx_if.o_frame_err}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single byte with exact push timing.
    fork
      send_frame(8'h55, 0);
      begin
        repeat (STOP_OFS - 1) @(posedge clk);
        #1;
        chk("t1_before_stop", {31'b0, rx_if.o_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_at_stop", {31'b0, rx_if.o_valid}, 32'd1);
        chk("t1_data", {24'b0, rx_if.o_data}, 32'h55);
      end
    join
    model_push(8'h55);
    check_status("t1");
    drain(DEPTH + 1);
    check_status("t1_drained");

    // Five bytes without popping: the fifth overflows.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0);
      model_push(8'(i));
      check_status("t2");
    end
    drain(DEPTH + 2);
    check_status("t2_drained");
    clr_flags();
    check_status("t2_cleared");

    // Bad stop bit held low, then a good frame.
    fork
      send_frame(8'hA3, 3 * DIV);
      begin
        repeat (2300) @(posedge clk);
        #1;
        chk("t3_wait_high", 32'(dut.state), 32'(ST_WAIT_HIGH));
        chk("t3_fe_set", {31'b0, rx_if.o_frame_err}, 32'd1);
      end
    join
    exp_fe = 1'b1;
    check_status("t3_bad");
    chk("t3_idle", 32'(dut.state), 32'(ST_IDLE));
    send_frame(8'h3C, 0);
    model_push(8'h3C);
    check_status("t3_good");
    drain(2);

    // Start glitch shorter than half a bit.
    hold(1'b0, 50);
    hold(1'b1, 300);
    chk("t4_idle", 32'(dut.state), 32'(ST_IDLE));
    check_status("t4");
    clr_flags();

    // Full FIFO, pop coinciding with the push of 0x7E.
    for (int i = 0; i < DEPTH; i++) begin
      fill_b = 8'($urandom_range(0, 255));
      send_frame(fill_b, 0);
      model_push(fill_b);
    end
    check_status("t5a_full");
    fork
      send_frame(8'h7E, 0);
      begin
        repeat (STOP_OFS - 1) @(posedge clk);
        #1;
        rx_if.i_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_if.i_ready = 1'b0;
      end
    join
    model_push(8'h7E);
    check_status("t5a_push_pop");
    drain(DEPTH + 1);
    check_status("t5a_drained");

    // Clear coinciding with a new frame error.
    send_frame(8'h12, DIV);
    exp_fe = 1'b1;
    check_status("t5b_first");
    fork
      send_frame(8'h5A, DIV);
      begin
        repeat (STOP_OFS - 1) @(posedge clk);
        #1;
        rx_if.i_clr_err = 1'b1;
        @(posedge clk);
        #1;
        rx_if.i_clr_err = 1'b0;
      end
    join
    exp_ovr = 1'b0;
    exp_fe  = 1'b1;
    check_status("t5b_coincide");
    clr_flags();
    check_status("t5b_cleared");

    // Reset during data bit 4 with data buffered and a flag set.
    send_frame(8'h99, 0);
    model_push(8'h99);
    send_frame(8'h00, DIV);
    exp_fe = 1'b1;
    check_status("t6_pre");
    hold(1'b0, DIV);
    for (int k = 0; k < 4; k++) hold(k[0], DIV);
    hold(1'b1, 100);
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, rx_if.o_valid}, 32'd0);
    chk("t6_rst_data", {24'b0, rx_if.o_data}, 32'd0);
    chk("t6_rst_ovr", {31'b0, rx_if.o_overrun}, 32'd0);
    chk("t6_rst_fe", {31'b0, rx_if.o_frame_err}, 32'd0);
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    chk("t6_idle", 32'(dut.state), 32'(ST_IDLE));
    check_status("t6_after");
    send_frame(8'hC9, 0);
    model_push(8'hC9);
    check_status("t6_c9");
    drain(2);

    // Random bytes, random gaps, random partial drains.
    for (int i = 0; i < 6; i++) begin
      int gap;
      gap   = int'($urandom_range(0, 20));
      rnd_b = 8'($urandom_range(0, 255));
      if (gap > 0) hold(1'b1, gap);
      send_frame(rnd_b, 0);
      model_push(rnd_b);
      check_status("rnd");
      if ($urandom_range(0, 2) == 0) drain(int'($urandom_range(1, 3)));
    end
    drain(DEPTH + 1);
    check_status("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
